// File: rtl/xiyiji_pkg.sv
// Shared definitions for the washer front panel: mode codes seen by the
// controller and the panel session-state encodings.
package xiyiji_pkg;

   typedef enum logic [1:0] {
      M0 = 2'd0,
      M1 = 2'd1,
      M2 = 2'd2,
      M3 = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      PS_IDLE  = 2'd0,
      PS_ARMED = 2'd1,
      PS_RUN   = 2'd2,
      PS_HALT  = 2'd3
   } panel_state_t;

   // Mode rotation used by the select button; M0 is only ever a start point.
   function automatic mode_t next_mode(input mode_t m);
      case (m)
         M1:      return M2;
         M2:      return M3;
         default: return M1;
      endcase
   endfunction

endpackage

// File: rtl/xiyiji_panel_if.sv
// Panel <-> board/controller signal bundle. The master side owns the raw
// buttons and the done alarm; the slave side is the panel conditioner.
interface xiyiji_panel_if;
   import xiyiji_pkg::*;

   logic         btn_select;
   logic         btn_start;
   logic         btn_emergency;
   logic         done;
   logic         sec_tick;
   logic         sec_clk;
   mode_t        mode;
   logic         start_lvl;
   logic         emergency_n;
   panel_state_t state;

   modport master (
      output btn_select, btn_start, btn_emergency, done,
      input  sec_tick, sec_clk, mode, start_lvl, emergency_n, state
   );

   modport slave (
      input  btn_select, btn_start, btn_emergency, done,
      output sec_tick, sec_clk, mode, start_lvl, emergency_n, state
   );

endinterface

// File: rtl/xiyiji_panel_debounce.sv
// One button channel: 2-flop synchroniser, stability counter and a registered
// one-cycle press pulse on an accepted 1->0 (active-low press) transition.
module panel_debounce #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_n,
   output logic level,
   output logic press
);

   localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync_p0, sync_p1;
   logic          stable, stable_d;
   logic [CW-1:0] cnt;

   // stage: synchroniser, then stability count against the accepted level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0  <= 1'b1;
         sync_p1  <= 1'b1;
         stable   <= 1'b1;
         stable_d <= 1'b1;
         cnt      <= '0;
         press    <= 1'b0;
      end else begin
         sync_p0  <= raw_n;
         sync_p1  <= sync_p0;
         stable_d <= stable;
         press    <= stable_d & ~stable;
         if (sync_p1 != stable) begin
            if (cnt == CNT_LAST) begin
               stable <= sync_p1;
               cnt    <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign level = stable;

endmodule

// File: rtl/xiyiji_panel.sv
// Front-panel conditioner: debounced buttons, 1 Hz tick/clock divider and the
// session FSM that drives the controller's mode/start/emergency levels.
module xiyiji_panel
   import xiyiji_pkg::*;
#(
   parameter int DEB_CYCLES = 1000000,
   parameter int TICK_DIV   = 50000000
) (
   input  logic          clk,
   input  logic          rst,
   xiyiji_panel_if.slave p
);

   localparam int DW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(TICK_DIV / 2 - 1);

   logic lvl_sel, lvl_start, lvl_emg;
   logic pr_sel, pr_start, pr_emg;
   logic levels_unused;

   panel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
      .clk(clk), .rst(rst), .raw_n(p.btn_select), .level(lvl_sel), .press(pr_sel)
   );
   panel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
      .clk(clk), .rst(rst), .raw_n(p.btn_start), .level(lvl_start), .press(pr_start)
   );
   panel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_emg (
      .clk(clk), .rst(rst), .raw_n(p.btn_emergency), .level(lvl_emg), .press(pr_emg)
   );

   // Only press events drive the session; the held levels are not needed here.
   assign levels_unused = ^{lvl_sel, lvl_start, lvl_emg};

   logic [DW-1:0] div_cnt;
   logic          tick_q, sclk_q;

   // stage: free-running second divider, independent of the session FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         tick_q  <= 1'b0;
         sclk_q  <= 1'b0;
      end else begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
         tick_q  <= (div_cnt == DIV_LAST);
         if ((div_cnt == DIV_LAST) || (div_cnt == DIV_HALF))
            sclk_q <= ~sclk_q;
      end
   end

   panel_state_t state_q, state_d;
   mode_t        mode_q, mode_d;
   logic         start_q, start_d;
   logic         emg_n_q, emg_n_d;

   // stage: session FSM register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= PS_IDLE;
         mode_q  <= M0;
         start_q <= 1'b0;
         emg_n_q <= 1'b1;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         start_q <= start_d;
         emg_n_q <= emg_n_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      start_d = start_q;
      emg_n_d = emg_n_q;
      if (pr_emg) begin
         // Emergency overrides every other event arriving in the same cycle.
         if (state_q != PS_HALT) begin
            state_d = PS_HALT;
            start_d = 1'b0;
            emg_n_d = 1'b0;
         end
      end else begin
         case (state_q)
            PS_IDLE: begin
               if (pr_sel) begin
                  mode_d  = M1;
                  state_d = PS_ARMED;
               end
            end
            PS_ARMED: begin
               if (pr_start) begin
                  start_d = 1'b1;
                  state_d = PS_RUN;
               end else if (pr_sel) begin
                  mode_d = next_mode(mode_q);
               end
            end
            PS_RUN: begin
               if (p.done) begin
                  start_d = 1'b0;
                  state_d = PS_ARMED;
               end
            end
            PS_HALT: begin
               if (pr_start) begin
                  emg_n_d = 1'b1;
                  state_d = PS_ARMED;
               end
            end
            default: state_d = PS_IDLE;
         endcase
      end
   end

   assign p.sec_tick    = tick_q;
   assign p.sec_clk     = sclk_q;
   assign p.mode        = mode_q;
   assign p.start_lvl   = start_q;
   assign p.emergency_n = emg_n_q;
   assign p.state       = state_q;

endmodule

// File: tb/tb_xiyiji_panel.sv
// Bench for xiyiji_panel with DEB_CYCLES=4, TICK_DIV=10: directed sessions,
// then random button/done traffic against an event-level session model.
module tb_xiyiji_panel;

   localparam int DEB = 4;
   localparam int DIV = 10;

   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   // Event-level session model: 0 idle, 1 armed, 2 run, 3 halt.
   int   m_state, m_mode, m_start, m_emerg;

   xiyiji_panel_if p ();

   xiyiji_panel #(.DEB_CYCLES(DEB), .TICK_DIV(DIV)) dut (
      .clk(clk),
      .rst(rst),
      .p  (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_mode  = 0;
      m_start = 0;
      m_emerg = 1;
   endtask

   // Apply the session rules to one cycle's worth of press/done events.
   task automatic model_apply(input bit sel, input bit st, input bit emg, input bit dn);
      if (emg) begin
         if (m_state != 3) begin
            m_state = 3;
            m_start = 0;
            m_emerg = 0;
         end
      end else if (m_state == 0) begin
         if (sel) begin
            m_mode  = 1;
            m_state = 1;
         end
      end else if (m_state == 1) begin
         if (st) begin
            m_start = 1;
            m_state = 2;
         end else if (sel) begin
            m_mode = (m_mode % 3) + 1;
         end
      end else if (m_state == 2) begin
         if (dn) begin
            m_start = 0;
            m_state = 1;
         end
      end else begin
         if (st) begin
            m_emerg = 1;
            m_state = 1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".mode"},        p.mode,        m_mode);
      chk({tag, ".start_lvl"},   p.start_lvl,   m_start);
      chk({tag, ".emergency_n"}, p.emergency_n, m_emerg);
      chk({tag, ".state"},       p.state,       m_state);
   endtask

   // One clock; the divider outputs are checked every cycle after reset release.
   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("sec_tick", p.sec_tick, ((cyc % DIV) == 0) ? 1 : 0);
      chk("sec_clk",  p.sec_clk,  (cyc / (DIV / 2)) % 2);
   endtask

   task automatic set_buttons(input bit sel, input bit st, input bit emg);
      p.btn_select    = ~sel;
      p.btn_start     = ~st;
      p.btn_emergency = ~emg;
   endtask

   // Press the masked buttons together for 'hold' cycles; the effect must land
   // exactly DEB+4 edges after the falling edge. Optionally raise done on that edge.
   task automatic press(input string tag, input bit sel, input bit st, input bit emg,
                        input int hold, input bit dn);
      int n;
      n = (hold > DEB + 4) ? hold : DEB + 4;
      set_buttons(sel, st, emg);
      for (int i = 1; i <= n; i++) begin
         if (i == DEB + 4 && dn) p.done = 1'b1;
         step();
         if (i == DEB + 4) begin
            p.done = 1'b0;
            model_apply(sel, st, emg, dn);
            check_outputs({tag, ".post"});
         end
         if (i == DEB + 3) check_outputs({tag, ".pre"});
         if (i == hold) set_buttons(0, 0, 0);
      end
      repeat (DEB + 6) step();
      check_outputs({tag, ".release"});
   endtask

   task automatic glitch(input string tag, input bit sel, input bit st, input bit emg,
                         input int hold);
      set_buttons(sel, st, emg);
      repeat (hold) step();
      set_buttons(0, 0, 0);
      repeat (DEB + 8) step();
      check_outputs(tag);
   endtask

   task automatic done_pulse(input string tag);
      p.done = 1'b1;
      step();
      p.done = 1'b0;
      model_apply(0, 0, 0, 1);
      check_outputs(tag);
   endtask

   // Drop reset between edges, confirm immediate clearing, release at a later negedge.
   task automatic async_reset(input string tag);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_outputs(tag);
      chk({tag, ".sec_tick"}, p.sec_tick, 0);
      chk({tag, ".sec_clk"},  p.sec_clk,  0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      cyc = 0;
   endtask

   initial begin
      int r, h;
      rst    = 1'b0;
      p.done = 1'b0;
      set_buttons(0, 0, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outputs("reset");
      chk("reset.sec_tick", p.sec_tick, 0);
      chk("reset.sec_clk",  p.sec_clk,  0);
      rst = 1'b1;
      cyc = 0;

      // Idle divider run
      repeat (32) step();
      check_outputs("idle");

      // Short glitch rejected, long press accepted with fixed latency
      glitch("glitch3", 1, 0, 0, 3);
      press("sel_long", 1, 0, 0, 12, 0);

      // Mode rotation from a fresh reset
      async_reset("rst_a");
      for (int i = 0; i < 4; i++) press("sel_rot", 1, 0, 0, DEB, 0);

      // Start ignored in IDLE, then a full session
      async_reset("rst_b");
      press("start_idle", 0, 1, 0, 5, 0);
      press("sel1", 1, 0, 0, 6, 0);
      press("sel2", 1, 0, 0, 6, 0);
      press("start_run", 0, 1, 0, 6, 0);
      press("sel_in_run", 1, 0, 0, 6, 0);
      done_pulse("done_run");

      // Emergency coinciding with done, then recovery
      press("start_run2", 0, 1, 0, 5, 0);
      press("emg_done", 0, 0, 1, 5, 1);
      press("sel_halt", 1, 0, 0, 5, 0);
      press("start_halt", 0, 1, 0, 5, 0);

      // Asynchronous reset while running
      press("start_run3", 0, 1, 0, 5, 0);
      async_reset("rst_run");
      repeat (12) step();
      check_outputs("after_rst");

      // Random traffic
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(9, 0);
         h = $urandom_range(DEB + 4, DEB);
         case (r)
            0, 1, 2: press("rnd_sel", 1, 0, 0, h, 0);
            3, 4:    press("rnd_start", 0, 1, 0, h, 0);
            5:       press("rnd_emg", 0, 0, 1, h, 0);
            6:       done_pulse("rnd_done");
            7:       glitch("rnd_glitch", r[0], ~r[0], 0, $urandom_range(DEB - 1, 1));
            8:       press("rnd_sel_start", 1, 1, 0, h, 0);
            default: press("rnd_emg_done", 0, 0, 1, h, 1);
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
